// File: rtl/pipe_skid_stage_pkg.sv
// Shared types for the pipeline stage registers: byte order, exception codes, stage state and payload.
package pipe_skid_stage_pkg;

    localparam int unsigned ORDER     = 0;  // byte order of the databus: 0 = little-endian
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned PC_W_DEF   = 32;
    localparam int unsigned EXC_W_DEF  = 5;
    localparam int unsigned CNT_W_DEF  = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_MOD  = 5'd1,
        EXC_TLBL = 5'd2,
        EXC_TLBS = 5'd3,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_CPU  = 5'd11,
        EXC_OV   = 5'd12
    } ExcCode_Define;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] instr;
        logic [PC_W_DEF-1:0]   pc;
        logic                  bd;
        logic [EXC_W_DEF-1:0]  exc;
    } pipe_payload_t;

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Upstream/downstream handshake bundle of one pipeline stage; slave = the stage, master = its surroundings.
interface pipe_skid_stage_if
    import pipe_skid_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned PC_W   = PC_W_DEF,
    parameter int unsigned EXC_W  = EXC_W_DEF
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_instr;
    logic [PC_W-1:0]   in_pc;
    logic              in_bd;
    logic [EXC_W-1:0]  in_exc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [PC_W-1:0]   out_pc;
    logic              out_bd;
    logic [EXC_W-1:0]  out_exc;

    modport master (
        output flush, in_valid, in_instr, in_pc, in_bd, in_exc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_bd, out_exc
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, in_bd, in_exc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_bd, out_exc
    );
endinterface

// File: rtl/pipe_skid_stage_perf_cnt.sv
// Saturating up-counter with synchronous clear; used for stage stall/bubble statistics.
module pipe_perf_cnt
    import pipe_skid_stage_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake, flush and a 2-entry skid buffer.
// Optional macro PIPE_SKID_PERF_EN adds stall_cnt/bubble_cnt performance counters.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int unsigned    DATA_W   = DATA_W_DEF,
    parameter int unsigned    PC_W     = PC_W_DEF,
    parameter int unsigned    EXC_W    = EXC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
`ifdef PIPE_SKID_PERF_EN
    ,
    parameter int unsigned    CNT_W    = CNT_W_DEF
`endif
) (
    input  logic               clk,
    input  logic               reset,
    pipe_skid_stage_if.slave   bus
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
`endif
);
    localparam int unsigned PAY_W = DATA_W + PC_W + 1 + EXC_W;

    localparam logic [1:0] ST_EMPTY = 2'(EMPTY);
    localparam logic [1:0] ST_ONE   = 2'(ONE);
    localparam logic [1:0] ST_FULL  = 2'(FULL);

    logic [1:0]       state_q, state_d;
    logic [PAY_W-1:0] main_q, main_d;
    logic [PAY_W-1:0] skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [PAY_W-1:0] in_pay;
    logic             push, pop;

    assign in_pay = {bus.in_instr, bus.in_pc, bus.in_bd, bus.in_exc};
    assign push   = bus.in_valid & in_ready_q;
    assign pop    = out_valid_q & bus.out_ready;

    // Next state: main register is the head, skid holds the one payload accepted during a stall
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d = ST_ONE;
                    main_d  = in_pay;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    main_d = in_pay;
                end else if (push) begin
                    state_d = ST_FULL;
                    skid_d  = in_pay;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush drops every entry (and any offered push) but leaves the payload fields untouched
        if (bus.flush) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_q      <= {DATA_W'(0), RESET_PC, 1'b0, EXC_W'(0)};
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign {bus.out_instr, bus.out_pc, bus.out_bd, bus.out_exc} = main_q;

`ifdef PIPE_SKID_PERF_EN
    pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear_i (1'b0),
        .inc_i   (out_valid_q & ~bus.out_ready),
        .cnt_o   (stall_cnt)
    );

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear_i (1'b0),
        .inc_i   (~out_valid_q),
        .cnt_o   (bubble_cnt)
    );
`endif

endmodule
